// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a combinational multi-cycle multiplier. It captures the
// operand magnitudes, waits a fixed settle time, then registers the sign-corrected product.
//
// state  | meaning
// IDLE   | ready for a new operand pair
// WAIT   | operands held on the multiplier inputs while the tree settles
// DONE   | result registered, waiting for the consumer to accept it
module mul_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_zero,
    output logic               out_ovf,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               neg_q, neg_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] out_p_q, out_p_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [2*WIDTH-1:0] prod_fix;
    logic               ovf_fix;

    assign prod_fix = neg_q ? (2*WIDTH)'(-mul_p) : mul_p;

    // Signed results fit in WIDTH bits only when the top WIDTH+1 bits are a pure sign extension.
    always_comb begin
        ovf_fix = 1'b0;
        if (sgn_q)
            ovf_fix = !((&prod_fix[2*WIDTH-1:WIDTH-1]) || !(|prod_fix[2*WIDTH-1:WIDTH-1]));
        else
            ovf_fix = |prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        out_p_d = out_p_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mul_a_d = (in_signed && in_a[WIDTH-1]) ? WIDTH'(-in_a) : in_a;
                    mul_b_d = (in_signed && in_b[WIDTH-1]) ? WIDTH'(-in_b) : in_b;
                    neg_d   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    sgn_d   = in_signed;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_p_d = prod_fix;
                    zero_d  = (prod_fix == '0);
                    ovf_d   = ovf_fix;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            out_p_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            out_p_q <= out_p_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_p     = out_p_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;

endmodule
